// File: rtl/cache_pkg.sv
// Shared types for the cache refill controller.
// Holds the refill FSM state encoding.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } refill_state_t;

endpackage

// File: rtl/cache_refill_controller_sat_counter.sv
// Saturating event counter used for hit/miss statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Refill controller between a core, a two-way LRU cache and memory.
// Write-through, write-allocate; one outstanding access at a time.
module cache_refill_controller
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int BLOCK_SIZE = 32,
    parameter int CNT_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic [ADDR_SIZE-1:0]  core_addr,
    input  logic                  core_we,
    input  logic [BLOCK_SIZE-1:0] core_wdata,
    output logic [BLOCK_SIZE-1:0] core_rdata,
    output logic                  core_ready,
    output logic [ADDR_SIZE-1:0]  cache_addr,
    output logic                  cache_we,
    output logic [BLOCK_SIZE-1:0] cache_wdata,
    input  logic [BLOCK_SIZE-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_SIZE-1:0]  mem_req_addr,
    output logic                  mem_req_we,
    output logic [BLOCK_SIZE-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_resp_data,
    output logic [CNT_SIZE-1:0]   hit_count,
    output logic [CNT_SIZE-1:0]   miss_count
);

    refill_state_t state, state_next;

    logic [ADDR_SIZE-1:0]  addr_q;
    logic                  we_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic [BLOCK_SIZE-1:0] fill_q;
    logic                  hit_inc;
    logic                  miss_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fill_q  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && core_req) begin
                addr_q  <= core_addr;
                we_q    <= core_we;
                wdata_q <= core_wdata;
            end
            // Only read refills carry data; write acks are dataless
            if (state == MEM_WAIT && mem_resp_valid && !we_q) begin
                fill_q <= mem_resp_data;
            end
        end
    end

    assign cache_addr    = addr_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;

    always_comb begin
        state_next    = state;
        core_rdata    = '0;
        core_ready    = 1'b0;
        cache_we      = 1'b0;
        cache_wdata   = '0;
        mem_req_valid = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        unique case (state)
            IDLE: begin
                if (core_req) state_next = LOOKUP;
            end
            LOOKUP: begin
                hit_inc  = cache_hit;
                miss_inc = !cache_hit;
                if (we_q) begin
                    cache_we    = 1'b1;
                    cache_wdata = wdata_q;
                    state_next  = MEM_REQ;
                end else if (cache_hit) begin
                    core_rdata = cache_rdata;
                    core_ready = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    if (we_q) begin
                        core_ready = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                cache_we    = 1'b1;
                cache_wdata = fill_q;
                core_rdata  = fill_q;
                core_ready  = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    sat_counter #(.WIDTH(CNT_SIZE)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_SIZE)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule
